// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory request, and the IF/ID holding register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic [31:0] imemload,
   output logic [31:0] npc,
   output logic        valid,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   typedef enum logic {FETCH, HALTED} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] imemload_q, imemload_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic        load_ev;
   logic        held;

   // Decode holding a live instruction it cannot accept yet
   assign held    = valid_q && stall;
   assign iREN    = (state_q == FETCH) && !held && !RST;
   assign iaddr   = pc_q;
   assign load_ev = ihit && iREN && !redirect && !halt;

   assign imemload = imemload_q;
   assign npc      = npc_q;
   assign valid    = valid_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      imemload_d = imemload_q;
      npc_d      = npc_q;
      valid_d    = valid_q;
      if (state_q == FETCH) begin
         if (halt && valid_q) begin
            state_d = HALTED;
            valid_d = 1'b0;
         end else if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
         end else if (load_ev) begin
            imemload_d = iload;
            npc_d      = pc_q + 32'd4;
            pc_d       = pc_q + 32'd4;
            valid_d    = 1'b1;
         end else if (!stall) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= FETCH;
         pc_q       <= PC_INIT;
         imemload_q <= 32'h0;
         npc_q      <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         imemload_q <= imemload_d;
         npc_q      <= npc_d;
         valid_q    <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   // Both counters stop in HALTED: load_ev needs iREN and valid is already clear there
   always_comb begin
      fetch_count_d = fetch_count_q;
      stall_count_d = stall_count_q;
      if (load_ev)
         fetch_count_d = fetch_count_q + 32'd1;
      if ((state_q == FETCH) && held)
         stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_count_q <= 32'h0;
         stall_count_q <= 32'h0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`else
   assign fetch_count = 32'h0;
   assign stall_count = 32'h0;
`endif

endmodule
